// File: rtl/hazard_pkg.sv
// Shared types and widths for the RVX10-P pipeline hazard sequencer.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  // ALU operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Multi-cycle sequencing state
  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hs_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX source operand from the MEM/WB write ports.
// Latency: combinational.
// Backpressure: none; MEM takes priority over WB, and x0 is never forwarded.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [REG_IDX_W-1:0] rd_m,
  input  logic [REG_IDX_W-1:0] rd_w,
  input  logic                 reg_write_m,
  input  logic                 reg_write_w,
  output fwd_sel_t             sel
);

  // Pick the youngest in-flight producer of rs
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush/forward control for the 5-stage core plus a multi-cycle EX sequencer with watchdog.
// Latency: stalls, flushes and forwards are combinational; mc_timeout and counters update on the edge.
// Backpressure: a multi-cycle op holds F/D/E and bubbles MEM until mc_done or the watchdog releases it.
// Optional: define HAZARD_PERF_EN to build the stall/flush/multi-cycle performance counters.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] Rs1E,
  input  logic [REG_IDX_W-1:0] Rs2E,
  input  logic [REG_IDX_W-1:0] RdE,
  input  logic                 ResultSrcE0,
  input  logic                 PCSrcE,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 mc_start_e,
  input  logic                 mc_done,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 mc_busy,
  output logic                 mc_timeout,
  output logic [CNT_W-1:0]     perf_stall_cnt,
  output logic [CNT_W-1:0]     perf_flush_cnt,
  output logic [CNT_W-1:0]     perf_mc_cnt
);

  localparam int WD_W = $clog2(MC_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

  hs_state_t       state, state_next;
  logic [WD_W-1:0] wd_cnt;
  logic            lw_stall;
  logic            wd_expired;
  logic            release_mc;
  fwd_sel_t        fwd_a, fwd_b;

  fwd_unit u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  assign lw_stall   = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign wd_expired = (wd_cnt == WD_LAST);
  // Leaving MC_WAIT this cycle, either on a real result or on the watchdog
  assign release_mc = (state == MC_WAIT) && (mc_done || wd_expired);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next state and stage-register controls; branch flush outranks load-use stall
  always_comb begin
    state_next = state;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    mc_busy    = 1'b0;
    case (state)
      RUN: begin
        if (mc_start_e) begin
          // A zero-latency op (done on the start cycle) passes through untouched
          if (!mc_done) begin
            StallF     = 1'b1;
            StallD     = 1'b1;
            StallE     = 1'b1;
            FlushM     = 1'b1;
            state_next = MC_WAIT;
          end
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MC_WAIT: begin
        if (release_mc) begin
          state_next = RUN;
        end else begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          mc_busy = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Watchdog counts cycles spent waiting and clears whenever the op is released
  always_ff @(posedge clk) begin
    if (reset || (state != MC_WAIT) || release_mc) wd_cnt <= '0;
    else                                          wd_cnt <= wd_cnt + WD_W'(1);
  end

  // Sticky watchdog error, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)                                              mc_timeout <= 1'b0;
    else if ((state == MC_WAIT) && !mc_done && wd_expired) mc_timeout <= 1'b1;
  end

`ifdef HAZARD_PERF_EN
  // Free-running, wrapping event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_mc_cnt    <= '0;
    end else begin
      if (StallF)             perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (FlushD || FlushE)   perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (state == MC_WAIT)   perf_mc_cnt    <= perf_mc_cnt + CNT_W'(1);
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
  assign perf_mc_cnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (watchdog shortened to 8 cycles).
// Latency: inputs applied 1ns after a rising edge, outputs checked 2ns later.
// Backpressure: not applicable.
module tb_hazard_sequencer;
  import hazard_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, mc_start_e, mc_done;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             mc_busy, mc_timeout;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt, perf_mc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .Rs1D           (Rs1D),
    .Rs2D           (Rs2D),
    .Rs1E           (Rs1E),
    .Rs2E           (Rs2E),
    .RdE            (RdE),
    .ResultSrcE0    (ResultSrcE0),
    .PCSrcE         (PCSrcE),
    .RdM            (RdM),
    .RdW            (RdW),
    .RegWriteM      (RegWriteM),
    .RegWriteW      (RegWriteW),
    .mc_start_e     (mc_start_e),
    .mc_done        (mc_done),
    .StallF         (StallF),
    .StallD         (StallD),
    .StallE         (StallE),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .FlushM         (FlushM),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE),
    .mc_busy        (mc_busy),
    .mc_timeout     (mc_timeout),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_mc_cnt    (perf_mc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pack {StallF,StallD,StallE,FlushD,FlushE,FlushM,mc_busy} for compact checks
  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy};
  endfunction

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    mc_start_e = 0; mc_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state, idle inputs
    chk("rst_ctl",     32'(ctl()), 32'h00);
    chk("rst_fwda",    32'(ForwardAE), 32'h0);
    chk("rst_fwdb",    32'(ForwardBE), 32'h0);
    chk("rst_timeout", 32'(mc_timeout), 32'h0);
    chk("rst_pstall",  perf_stall_cnt, 32'h0);
    chk("rst_pflush",  perf_flush_cnt, 32'h0);
    chk("rst_pmc",     perf_mc_cnt, 32'h0);

    // Forwarding priority on operand A
    tick();
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs2E = 9;
    settle();
    chk("fwda_mem", 32'(ForwardAE), 32'h2);
    chk("fwdb_none", 32'(ForwardBE), 32'h0);
    RdM = 0; settle();
    chk("fwda_wb_rdm0", 32'(ForwardAE), 32'h1);
    RegWriteW = 0; settle();
    chk("fwda_rf", 32'(ForwardAE), 32'h0);
    // Operand B: WB match while MEM write disabled; then x0 never forwarded
    Rs2E = 3; RdM = 3; RegWriteM = 0; RdW = 3; RegWriteW = 1; settle();
    chk("fwdb_wb", 32'(ForwardBE), 32'h1);
    RegWriteM = 1; settle();
    chk("fwdb_mem", 32'(ForwardBE), 32'h2);
    Rs2E = 0; RdM = 0; RdW = 0; settle();
    chk("fwdb_x0", 32'(ForwardBE), 32'h0);
    chk("fwd_no_ctl", 32'(ctl()), 32'h00);

    // Load-use via Rs2D: one bubble, then the load has moved on
    tick(); idle();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; settle();
    chk("lw_rs2", 32'(ctl()), 32'b1100100);
    tick();
    ResultSrcE0 = 0; settle();
    chk("lw_one_cycle", 32'(ctl()), 32'h00);
    ResultSrcE0 = 1; RdE = 4; Rs1D = 4; Rs2D = 1; settle();
    chk("lw_rs1", 32'(ctl()), 32'b1100100);
    RdE = 0; Rs1D = 0; Rs2D = 0; settle();
    chk("lw_rd0", 32'(ctl()), 32'h00);

    // Branch alone, then branch beating load-use
    tick(); idle();
    PCSrcE = 1; settle();
    chk("branch", 32'(ctl()), 32'b0001100);
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; settle();
    chk("branch_wins", 32'(ctl()), 32'b0001100);

    // mc_done without mc_start_e in RUN does nothing
    tick(); idle();
    mc_done = 1; settle();
    chk("done_idle", 32'(ctl()), 32'h00);

    // Zero-latency op: hazards ignored, stays in RUN
    tick(); idle();
    mc_start_e = 1; mc_done = 1; PCSrcE = 1; settle();
    chk("mc_zero", 32'(ctl()), 32'h00);
    tick(); idle(); settle();
    chk("mc_zero_run", 32'(ctl()), 32'h00);

    // Multi-cycle op, done on the 5th cycle (4 stalled cycles)
    tick();
    mc_start_e = 1; settle();
    chk("mc_start", 32'(ctl()), 32'b1110010);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 2) begin
        PCSrcE = 1; ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        Rs1E = 6; RdW = 6; RegWriteW = 1;
      end
      settle();
      chk("mc_wait", 32'(ctl()), 32'b1110011);
      if (i == 2) chk("mc_wait_fwd", 32'(ForwardAE), 32'h1);
    end
    tick(); idle();
    mc_start_e = 1; mc_done = 1; settle();
    chk("mc_done", 32'(ctl()), 32'h00);
    tick(); idle();
    ResultSrcE0 = 1; RdE = 2; Rs1D = 2; settle();
    chk("mc_back_run", 32'(ctl()), 32'b1100100);
    chk("mc_no_timeout", 32'(mc_timeout), 32'h0);

    // Watchdog: 8 stalled cycles, forced release on the 9th, sticky flag
    tick(); idle();
    mc_start_e = 1; settle();
    chk("wd_start", 32'(ctl()), 32'b1110010);
    for (int i = 1; i <= 7; i++) begin
      tick(); settle();
      chk("wd_wait", 32'(ctl()), 32'b1110011);
      chk("wd_flag_low", 32'(mc_timeout), 32'h0);
    end
    tick(); settle();
    chk("wd_release", 32'(ctl()), 32'h00);
    tick(); idle(); settle();
    chk("wd_flag_set", 32'(mc_timeout), 32'h1);
    chk("wd_run", 32'(ctl()), 32'h00);
    tick(); tick(); settle();
    chk("wd_flag_sticky", 32'(mc_timeout), 32'h1);

    // Reset during MC_WAIT
    tick();
    mc_start_e = 1;
    tick(); settle();
    chk("rst_mid_busy", 32'(ctl()), 32'b1110011);
    reset = 1'b1;
    tick(); idle();
    reset = 1'b0; settle();
    chk("rst_mid_ctl", 32'(ctl()), 32'h00);
    chk("rst_mid_timeout", 32'(mc_timeout), 32'h0);
    chk("rst_mid_pstall", perf_stall_cnt, 32'h0);
    chk("rst_mid_pmc", perf_mc_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block for the 5-stage RVX10-P core.
- Generates stall, flush and forwarding selects for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Sequences a multi-cycle EX operation (e.g. divide) through a small FSM with a watchdog.
- Sits beside the datapath. Its outputs drive the enables/clears of the stage registers and the ALU operand muxes.

Parameters:
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before a forced release.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source register indices in ID.
- Rs1E, Rs2E, RdE  in  5 each  source and destination indices in EX.
- ResultSrcE0  in  1  instruction in EX is a load.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- RdM, RdW  in  5 each  destination indices in MEM and WB.
- RegWriteM, RegWriteW  in  1 each  write-enable in MEM and WB.
- mc_start_e  in  1  instruction in EX is multi-cycle.
- mc_done  in  1  multi-cycle unit result valid this cycle.
- StallF, StallD, StallE  out  1 each  hold PC, IF/ID and ID/EX.
- FlushD, FlushE, FlushM  out  1 each  synchronous clear of IF/ID, ID/EX and EX/MEM.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 WB result, 10 MEM ALU result.
- mc_busy  out  1  FSM is in MC_WAIT.
- mc_timeout  out  1  sticky watchdog error flag.
- perf_stall_cnt, perf_flush_cnt, perf_mc_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset: FSM goes to RUN; watchdog counter cleared; mc_timeout cleared; counters cleared. Every output evaluates to 0 while inputs are idle.
- Forwarding (combinational, per operand, ForwardAE shown):
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00.
  - MEM has priority over WB.
- Load-use stall, RUN only: lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). It causes StallF, StallD and FlushE, giving a single bubble.
- Branch, RUN only: PCSrcE causes FlushD and FlushE.
- If lwStall and PCSrcE occur together, the flush wins: StallF=StallD=0, FlushD=FlushE=1.
- Multi-cycle op, RUN with mc_start_e:
  - Start cycle: if mc_done=1 in the same cycle, the result is ready (zero-latency op). Outputs stay normal and the FSM stays in RUN.
  - Otherwise StallF=StallD=StallE=1, FlushM=1, and the next state is MC_WAIT.
  - lwStall and PCSrcE are ignored while an mc op is in EX.
- MC_WAIT:
  - StallF=StallD=StallE=1, FlushM=1, mc_busy=1.
  - The watchdog increments each cycle.
  - On mc_done: stalls and FlushM deassert in that cycle, the EX result advances, the next state is RUN and the watchdog clears.
  - If the watchdog reaches MC_TIMEOUT-1 without mc_done: the same release happens and mc_timeout is set (sticky until reset).
  - Forwarding still evaluates normally.
- mc_done in RUN without mc_start_e is ignored.
- Reset asserted mid-MC_WAIT: the FSM returns to RUN on the next edge and all stalls drop.
- Stall and flush outputs are combinational from FSM state plus inputs; there is no added latency.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle StallF=1.
  - perf_flush_cnt increments each cycle FlushD|FlushE=1.
  - perf_mc_cnt increments each cycle in MC_WAIT.
  - All counters wrap at 2^CNT_W and clear on reset.
- Undefined: the ports remain and are tied to 0, with no counter flops.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - hs_state_t enum (RUN, MC_WAIT).
  - Width localparams REG_IDX_W=5.
- Sub-module fwd_unit: combinational, instanced once per operand. It takes a source index plus the MEM/WB write info and returns fwd_sel_t.

Test Plan:
- Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Then RdM=0 -> ForwardAE=01. Then RegWriteW=0 -> 00.
- ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. RdE=0 -> no stall.
- lwStall condition together with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- mc_start_e=1, mc_done after 4 cycles -> StallF/D/E and FlushM high for 4 cycles, low on the done cycle, mc_busy high for 3 cycles, FSM back to RUN.
- mc_start_e=1, mc_done never (MC_TIMEOUT=8) -> forced release after the 8th stalled cycle, mc_timeout=1 and sticky until reset.
- Reset pulse during MC_WAIT -> next cycle all outputs 0, mc_timeout=0, counters 0 (when HAZARD_PERF_EN is defined).
